// File: rtl/ahb_lite_mem_responder.sv
// ahb_lite_mem_responder: AHB-Lite slave bridging single transfers onto a req/ack memory backend
module ahb_lite_mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);
  typedef enum logic [2:0] {IDLE, ACCESS, DONE, ERR1, ERR2} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-3:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  accept, fault;
  logic [3:0]            be_new;
  // Address-phase decode, captured control, read data capture and next state
  always_comb begin
    accept  = HSEL & HREADY & HTRANS[1] & (state_q inside {IDLE, DONE, ERR2});
    fault   = (HADDR[31:ADDR_WIDTH] != BASE_ADDR[31:ADDR_WIDTH]) || (HSIZE > 3'd2) ||
              (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
    be_new  = HSIZE == 3'd0 ? 4'b0001 << HADDR[1:0] : HSIZE == 3'd1 ? 4'b0011 << HADDR[1:0] : 4'b1111;
    addr_d  = accept ? HADDR[ADDR_WIDTH-1:2] : addr_q;
    we_d    = accept ? HWRITE : we_q;
    be_d    = accept ? be_new : be_q;
    rdata_d = (state_q == ACCESS && mem_ack && !we_q) ? mem_rdata : rdata_q;
    state_d = state_q == ACCESS ? (mem_ack ? DONE : ACCESS) :
              state_q == ERR1   ? ERR2 :
              accept            ? (fault ? ERR1 : ACCESS) : IDLE;
  end
  // Bus response and backend strobes are pure functions of the state
  always_comb begin
    HREADYOUT = !(state_q == ACCESS || state_q == ERR1);
    HRESP     = state_q == ERR1 || state_q == ERR2;
    mem_req   = state_q == ACCESS;
    mem_we    = mem_req & we_q;
    mem_be    = mem_req ? be_q : 4'b0000;
    mem_addr  = addr_q;
    mem_wdata = HWDATA;
    HRDATA    = rdata_q;
  end
  // State and captured-control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_ahb_lite_mem_responder.sv
// tb_ahb_lite_mem_responder: randomized self-checking bench against a transaction-level model
module tb_ahb_lite_mem_responder;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int          AW   = 12;
  localparam logic [31:0] WIN  = 32'd1 << AW;
  logic          clk = 0, rst = 1;
  logic          HSEL = 0, HWRITE = 0, mem_ack = 0;
  logic [31:0]   HADDR = 0, HWDATA = 0, mem_rdata = 0;
  logic [1:0]    HTRANS = 0;
  logic [2:0]    HSIZE = 0;
  logic [31:0]   HRDATA, mem_wdata;
  logic          HREADYOUT, HRESP, mem_req, mem_we;
  logic [AW-3:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   exp_rd = 0;
  int            checks = 0, errors = 0;

  ahb_lite_mem_responder #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADYOUT), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack));

  always #5 clk = ~clk;

  function automatic bit m_fault(input logic [31:0] a, input logic [2:0] s);
    return (a - BASE) >= WIN || s > 3'd2 || (a % (32'd1 << s)) != 0;
  endfunction
  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] s);
    return s == 3'd0 ? 4'(1 << (a % 4)) : s == 3'd1 ? 4'(3 << (a % 4)) : 4'hF;
  endfunction
  function automatic logic [AW-3:0] m_waddr(input logic [31:0] a);
    return (AW-2)'((a - BASE) / 4);
  endfunction

  task automatic xfer(input logic [31:0] a, input logic [2:0] s, input bit w,
                      input logic [31:0] wd, input logic [31:0] rd, input int d);
    bit f;
    f = m_fault(a, s);
    HSEL = 1; HADDR = a; HTRANS = 2'b10; HWRITE = w; HSIZE = s;
    @(posedge clk); @(negedge clk);
    HTRANS = 2'b00; HWDATA = wd; HADDR = $urandom; HWRITE = ~w; HSIZE = 3'($urandom);
    if (f) begin
      checks++;
      if ({HREADYOUT, HRESP, mem_req} !== 3'b010) begin
        errors++; $display("FAIL err1 a=%h s=%0d got rdy/resp/req=%b want 010", a, s, {HREADYOUT, HRESP, mem_req});
      end
      @(negedge clk);
      checks++;
      if ({HREADYOUT, HRESP, mem_req} !== 3'b110) begin
        errors++; $display("FAIL err2 a=%h s=%0d got rdy/resp/req=%b want 110", a, s, {HREADYOUT, HRESP, mem_req});
      end
    end else begin
      for (int i = 0; i <= d; i++) begin
        checks++;
        if ({HREADYOUT, HRESP, mem_req, mem_we, mem_be, mem_addr} !== {2'b00, 1'b1, w, m_be(a, s), m_waddr(a)}) begin
          errors++;
          $display("FAIL access a=%h s=%0d cyc=%0d got rdy=%b resp=%b req=%b we=%b be=%b addr=%h want rdy=0 resp=0 req=1 we=%b be=%b addr=%h",
                   a, s, i, HREADYOUT, HRESP, mem_req, mem_we, mem_be, mem_addr, w, m_be(a, s), m_waddr(a));
        end
        if (w) begin
          checks++;
          if (mem_wdata !== wd) begin
            errors++; $display("FAIL wdata got %h want %h", mem_wdata, wd);
          end
        end
        mem_ack = (i == d);
        mem_rdata = (i == d) ? rd : $urandom;
        @(negedge clk);
      end
      mem_ack = 0;
      if (!w) exp_rd = rd;
      checks++;
      if ({HREADYOUT, HRESP, mem_req, HRDATA} !== {3'b100, exp_rd}) begin
        errors++;
        $display("FAIL done a=%h got rdy/resp/req=%b hrdata=%h want 100 hrdata=%h", a, {HREADYOUT, HRESP, mem_req}, HRDATA, exp_rd);
      end
    end
  endtask

  task automatic idle_cycle(input logic [1:0] t);
    HSEL = 1; HTRANS = t; HADDR = $urandom;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({HREADYOUT, HRESP, mem_req, HRDATA} !== {3'b100, exp_rd}) begin
      errors++;
      $display("FAIL idle htrans=%b got rdy/resp/req=%b hrdata=%h want 100 hrdata=%h", t, {HREADYOUT, HRESP, mem_req}, HRDATA, exp_rd);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({HRDATA, HREADYOUT, HRESP, mem_req, mem_we, mem_addr, mem_be} !== {32'h0, 3'b100, 1'b0, 10'h0, 4'h0}) begin
      errors++; $display("FAIL reset got hrdata=%h rdy=%b resp=%b req=%b we=%b addr=%h be=%b", HRDATA, HREADYOUT, HRESP, mem_req, mem_we, mem_addr, mem_be);
    end
    rst = 0;
    idle_cycle(2'b00);
  endtask

  task automatic test_word_read;
    xfer(BASE + 32'h10, 3'd2, 0, 32'h0, 32'hDEAD_BEEF, 0);
  endtask

  task automatic test_byte_write;
    xfer(BASE + 32'h7, 3'd0, 1, 32'hAA00_0000, 32'h0, 3);
  endtask

  task automatic test_errors;
    xfer(BASE + 32'h2, 3'd2, 0, 32'h0, 32'h0, 0);
    xfer(BASE + WIN, 3'd2, 0, 32'h0, 32'h0, 0);
    xfer(BASE + 32'h1, 3'd1, 1, 32'h0, 32'h0, 0);
    xfer(BASE + 32'h4, 3'd3, 0, 32'h0, 32'h0, 0);
    idle_cycle(2'b00);
  endtask

  task automatic test_back_to_back;
    xfer(BASE + 32'h40, 3'd2, 0, 32'h0, 32'h1234_5678, 1);
    xfer(BASE + 32'h46, 3'd1, 1, 32'hCAFE_0000, 32'h0, 0);
    xfer(BASE + 32'h2, 3'd2, 0, 32'h0, 32'h0, 0);
    xfer(BASE + 32'h81, 3'd0, 0, 32'h0, 32'h5A5A_A5A5, 2);
    idle_cycle(2'b00);
  endtask

  task automatic test_reset_mid_access;
    HSEL = 1; HADDR = BASE + 32'h20; HTRANS = 2'b10; HWRITE = 0; HSIZE = 3'd2;
    @(posedge clk); @(negedge clk);
    HTRANS = 2'b00; mem_ack = 0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL pre_reset_req got %b want 1", mem_req);
    end
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({mem_req, HREADYOUT, HRESP, HRDATA} !== {3'b010, 32'h0}) begin
        errors++; $display("FAIL reset_mid cyc=%0d got req/rdy/resp=%b hrdata=%h want 010 hrdata=0", i, {mem_req, HREADYOUT, HRESP}, HRDATA);
      end
    end
    rst = 0; exp_rd = 0;
    idle_cycle(2'b00);
  endtask

  task automatic test_idle_busy;
    for (int i = 0; i < 6; i++) idle_cycle(i % 2 ? 2'b01 : 2'b00);
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [2:0] s;
    for (int n = 0; n < 80; n++) begin
      s = ($urandom % 6 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom % 3);
      a = ($urandom % 8 == 0) ? $urandom : BASE + ($urandom % WIN);
      if ($urandom % 2 && s < 3'd3) a = a & ~((32'd1 << s) - 1);
      xfer(a, s, 1'($urandom), $urandom, $urandom, $urandom % 4);
      if ($urandom % 4 == 0) idle_cycle(2'($urandom % 2));
    end
    idle_cycle(2'b00);
  endtask

  initial begin
    test_reset;
    test_word_read;
    test_byte_write;
    test_errors;
    test_back_to_back;
    test_reset_mid_access;
    test_idle_busy;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
